// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream source arbiter family.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int src_id_width(input int src_count);
    return (src_count > 1) ? $clog2(src_count) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational rotate-priority pick: first set request searching upward from last+1, with wrap.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int SRC_COUNT = 4,
  parameter int ID_WIDTH  = src_id_width(SRC_COUNT)
) (
  input  logic [SRC_COUNT-1:0] req,
  input  logic [ID_WIDTH-1:0]  last,
  output logic                 pick_vld,
  output logic [ID_WIDTH-1:0]  pick_idx
);

  logic [ID_WIDTH-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = SRC_COUNT; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(last) + k) % SRC_COUNT);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/axis_downsizer_arbiter.sv
// Round-robin burst arbiter feeding one shared wide-to-narrow downsizer, tagging each
// wide word with its source index and that source's downsizer slice setting.
module axis_downsizer_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int SRC_COUNT  = 4,
  parameter int CFG_WIDTH  = 16
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [SRC_COUNT*CFG_WIDTH-1:0]    cfg_slices,
  input  logic [CFG_WIDTH-1:0]              cfg_burst,
  input  logic [SRC_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [SRC_COUNT-1:0]              s_axis_tvalid,
  output logic [SRC_COUNT-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [src_id_width(SRC_COUNT)-1:0] m_axis_tdest,
  output logic [CFG_WIDTH-1:0]              m_cfg_data,
  output logic [SRC_COUNT-1:0]              sts_grant
);

  localparam int IDW = src_id_width(SRC_COUNT);

  arb_state_e             state;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         last_idx;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_vld;
  logic [CFG_WIDTH-1:0]   slice_lat;
  logic [CFG_WIDTH-1:0]   burst_lat;
  logic [CFG_WIDTH-1:0]   burst_cnt;
  logic [CFG_WIDTH-1:0]   pick_slice;
  logic [DATA_WIDTH-1:0]  src_data;
  logic                   src_ready;
  logic                   src_vld;
  logic                   src_hs;
  logic                   burst_end;
  logic                   src_gap;

  axis_rr_picker #(
    .SRC_COUNT (SRC_COUNT),
    .ID_WIDTH  (IDW)
  ) u_picker (
    .req      (s_axis_tvalid),
    .last     (last_idx),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  assign pick_slice = cfg_slices[int'(pick_idx)*CFG_WIDTH +: CFG_WIDTH];
  assign src_data   = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign src_ready  = (state == ST_GRANT) && (!m_axis_tvalid || m_axis_tready);
  assign src_vld    = s_axis_tvalid[grant_idx];
  assign src_hs     = src_ready && src_vld;
  assign burst_end  = src_hs && (burst_cnt == burst_lat);
  // A missing word only ends the grant when it could actually have been taken.
  assign src_gap    = src_ready && !src_vld;

  always_comb begin
    s_axis_tready = '0;
    sts_grant     = '0;
    if (state == ST_GRANT) begin
      sts_grant[grant_idx]     = 1'b1;
      s_axis_tready[grant_idx] = src_ready;
    end
  end

  // Arbitration FSM, burst counter and config captured at grant time
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_idx  <= IDW'(SRC_COUNT - 1);
      slice_lat <= '0;
      burst_lat <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            slice_lat <= pick_slice;
            burst_lat <= cfg_burst;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (burst_end || src_gap) begin
            state    <= ST_IDLE;
            last_idx <= grant_idx;
          end else if (src_hs) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-entry output register; payload only moves on reload
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
      m_cfg_data    <= '0;
    end else if (src_hs) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= src_data;
      m_axis_tdest  <= grant_idx;
      m_cfg_data    <= slice_lat;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_downsizer_arbiter.sv
// Self-checking bench: per-source word generators, scoreboard on the m side, and
// per-scenario tables of expected tdest / slice / spacing of output words.
module tb_axis_downsizer_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int IW = 2;

  logic            aclk;
  logic            areset;
  logic [N*CW-1:0] cfg_slices;
  logic [CW-1:0]   cfg_burst;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [IW-1:0]   m_axis_tdest;
  logic [CW-1:0]   m_cfg_data;
  logic [N-1:0]    sts_grant;

  axis_downsizer_arbiter #(
    .DATA_WIDTH (DW),
    .SRC_COUNT  (N),
    .CFG_WIDTH  (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_slices    (cfg_slices),
    .cfg_burst     (cfg_burst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdest  (m_axis_tdest),
    .m_cfg_data    (m_cfg_data),
    .sts_grant     (sts_grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    int            dest;
    int            slice;
  } exp_t;

  typedef struct {
    int dest;
    int slice;
    int gap;   // cycles since previous output word, 0 = not checked
  } vec_t;

  exp_t exp_q[$];
  int   dest_log[$];
  int   slice_log[$];
  int   cyc_log[$];

  int       total = 0;
  int       bad   = 0;
  int       cycle = 0;
  int       m_words;
  int       seq[N];
  int       hs_cnt[N];
  int       exp_slice[N];
  logic [N-1:0] src_en;
  logic     m_rdy;
  int       hook;

  vec_t t1[$], t2[$], t3[$], t4[$], t5[$], t6[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i, input int s);
    return {8'(i), 24'(s)};
  endfunction

  task automatic set_slice(input int i, input int v);
    cfg_slices[i*CW +: CW] = CW'(v);
    exp_slice[i] = v;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    dest_log.delete();
    slice_log.delete();
    cyc_log.delete();
    m_words = 0;
    for (int i = 0; i < N; i++) hs_cnt[i] = 0;
  endtask

  // One clock: drive inputs after the falling edge, then account for the handshakes
  // that the next rising edge will complete.
  task automatic step();
    exp_t e;
    @(negedge aclk);
    s_axis_tvalid = src_en;
    m_axis_tready = m_rdy;
    for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = word_of(i, seq[i]);
    #1;
    cycle++;
    chk("ready_onehot", longint'($countones(s_axis_tready) <= 1), 1);
    for (int i = 0; i < N; i++) begin
      if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        exp_q.push_back('{word_of(i, seq[i]), i, exp_slice[i]});
        seq[i]++;
        hs_cnt[i]++;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_axis_tdata, e.data);
        chk("m_dest", m_axis_tdest, e.dest);
        chk("m_cfg", m_cfg_data, e.slice);
      end
      dest_log.push_back(int'(m_axis_tdest));
      slice_log.push_back(int'(m_cfg_data));
      cyc_log.push_back(cycle);
      m_words++;
    end
  endtask

  task automatic run_until(input int n, input int maxc);
    int c = 0;
    while (m_words < n && c < maxc) begin
      case (hook)
        3: if (hs_cnt[1] >= 3) src_en[1] = 1'b0;
        4: if (hs_cnt[0] >= 8) src_en[0] = 1'b0;
        5: begin
          if (hs_cnt[0] >= 2) cfg_slices[0 +: CW] = CW'(3);
          if (hs_cnt[0] >= 4) exp_slice[0] = 3;
          if (hs_cnt[0] >= 8) src_en[0] = 1'b0;
        end
        default: ;
      endcase
      step();
      c++;
    end
    if (m_words < n) chk("timeout_words", m_words, n);
  endtask

  task automatic drain(input string name);
    src_en = '0;
    m_rdy  = 1'b1;
    repeat (6) step();
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_tbl(input vec_t tbl[$], input string name);
    for (int k = 0; k < tbl.size(); k++) begin
      if (k >= dest_log.size()) begin
        chk({name, "_missing"}, dest_log.size(), k + 1);
      end else begin
        chk({name, "_dest"}, dest_log[k], tbl[k].dest);
        chk({name, "_slice"}, slice_log[k], tbl[k].slice);
        if (k > 0 && tbl[k].gap > 0)
          chk({name, "_gap"}, cyc_log[k] - cyc_log[k-1], tbl[k].gap);
      end
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    src_en = '0;
    m_rdy  = 1'b1;
    hook   = 0;
    repeat (2) step();
    clear_logs();
    areset = 1'b0;
  endtask

  initial begin
    // Expected output sequences per scenario
    for (int k = 0; k < 8; k++) t1.push_back('{2, 3, (k == 4) ? 2 : 1});
    for (int k = 0; k < 6; k++) t2.push_back('{(k % 3 == 2) ? 3 : (k % 3), 5 + ((k % 3 == 2) ? 3 : (k % 3)), 2});
    for (int k = 0; k < 3; k++) t3.push_back('{1, 6, 1});
    t3.push_back('{2, 7, 3});
    for (int k = 0; k < 7; k++) t3.push_back('{2, 7, 1});
    for (int k = 0; k < 8; k++) t4.push_back('{0, 5, (k == 2) ? 6 : 1});
    for (int k = 0; k < 8; k++) t5.push_back('{0, (k < 4) ? 1 : 3, (k == 4) ? 2 : 1});
    t6.push_back('{1, 6, 0});

    areset        = 1'b1;
    cfg_slices    = '0;
    cfg_burst     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i]       = 0;
      exp_slice[i] = 0;
    end
    src_en = '0;
    m_rdy  = 1'b1;
    hook   = 0;
    clear_logs();

    do_reset();
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tdest", m_axis_tdest, 0);
    chk("rst_m_cfg", m_cfg_data, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_grant", sts_grant, 0);

    // Single source, bursts of 4 with one idle cycle between grants
    set_slice(2, 3);
    cfg_burst = 16'd3;
    src_en    = 4'b0100;
    run_until(8, 60);
    check_tbl(t1, "single");
    drain("single");

    // Round robin, one word per grant
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, 5 + i);
    cfg_burst = 16'd0;
    src_en    = 4'b1011;
    run_until(6, 60);
    check_tbl(t2, "rr");
    drain("rr");

    // Source gap ends the grant early
    do_reset();
    cfg_burst = 16'd7;
    src_en    = 4'b0110;
    hook      = 3;
    run_until(11, 80);
    check_tbl(t3, "gap");
    drain("gap");

    // Output backpressure mid-burst
    do_reset();
    cfg_burst = 16'd7;
    src_en    = 4'b0001;
    hook      = 4;
    run_until(2, 40);
    m_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_tvalid", m_axis_tvalid, 1);
      chk("stall_tready", s_axis_tready, 0);
      if (exp_q.size() > 0) chk("stall_tdata", m_axis_tdata, exp_q[0].data);
      chk("stall_tdest", m_axis_tdest, 0);
      chk("stall_cfg", m_cfg_data, 5);
    end
    m_rdy = 1'b1;
    run_until(8, 60);
    drain("stall");
    check_tbl(t4, "stall");
    chk("stall_words_out", m_words, 8);
    chk("stall_words_in", hs_cnt[0], 8);

    // Slice change mid-burst applies at the next grant only
    do_reset();
    set_slice(0, 1);
    cfg_burst = 16'd3;
    src_en    = 4'b0001;
    hook      = 5;
    run_until(8, 60);
    drain("cfgchg");
    check_tbl(t5, "cfgchg");
    set_slice(0, 5);

    // Asynchronous reset with a full output register
    do_reset();
    cfg_burst = 16'd7;
    src_en    = 4'b1100;
    run_until(2, 40);
    chk("pre_rst_grant", sts_grant, 4'b0100);
    m_rdy = 1'b0;
    step();
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #1 areset = 1'b1;
    #1;
    chk("arst_m_tvalid", m_axis_tvalid, 0);
    chk("arst_m_tdata", m_axis_tdata, 0);
    chk("arst_m_tdest", m_axis_tdest, 0);
    chk("arst_m_cfg", m_cfg_data, 0);
    chk("arst_s_tready", s_axis_tready, 0);
    chk("arst_grant", sts_grant, 0);
    clear_logs();
    src_en = 4'b1010;
    m_rdy  = 1'b1;
    repeat (2) step();
    clear_logs();
    areset = 1'b0;
    run_until(1, 20);
    check_tbl(t6, "after_rst");
    drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_downsizer_arbiter.md
# axis_downsizer_arbiter

Round-robin arbiter that shares one wide-to-narrow AXI-Stream downsizer between SRC_COUNT wide sources. It grants one source at a time for a bounded burst of wide words and forwards that source's data through a single-entry output register. With each word it presents the downsizer's `cfg_data` slice setting for the granted source, so each source can emit a different number of narrow words per wide word. It sits directly upstream of `axis_downsizer`.

## Interface
- `DATA_WIDTH`, 128, wide word width (downsizer input width)
- `SRC_COUNT`, 4, number of requesting sources, 2..16
- `CFG_WIDTH`, 16, width of per-source slice setting and burst setting
- `aclk`  in  1  clock, all logic on rising edge
- `areset`  in  1  asynchronous, active-high reset
- `cfg_slices`  in  SRC_COUNT*CFG_WIDTH  per-source slice index of last narrow word (field i = source i), passed to downsizer
- `cfg_burst`  in  CFG_WIDTH  max wide words per grant minus 1
- `s_axis_tdata`  in  SRC_COUNT*DATA_WIDTH  source data, field i = source i
- `s_axis_tvalid`  in  SRC_COUNT  per-source valid
- `s_axis_tready`  out  SRC_COUNT  per-source ready, at most one bit high
- `m_axis_tdata`  out  DATA_WIDTH  to downsizer `s_axis_tdata`
- `m_axis_tvalid`  out  1  to downsizer `s_axis_tvalid`
- `m_axis_tready`  in  1  from downsizer `s_axis_tready`
- `m_axis_tdest`  out  clog2(SRC_COUNT)  source index of word on m side
- `m_cfg_data`  out  CFG_WIDTH  slice setting for word on m side, to downsizer `cfg_data`
- `sts_grant`  out  SRC_COUNT  one-hot current grant, 0 when idle

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any `s_axis_tvalid` is set, pick the first set bit searching upward, with wrap, from `last+1`. Latch grant index `g`, `cfg_slices[g]` and `cfg_burst` into internal registers. Clear the burst counter and go to GRANT. All `s_axis_tready` are 0 in IDLE.
- GRANT: `s_axis_tready[g] = ~m_axis_tvalid | m_axis_tready`. All other ready bits are 0.
- On each source handshake in GRANT:
  - load the output register with tdata, tdest=`g` and the latched slice setting;
  - increment the burst counter.
- Leave GRANT for IDLE and set `last = g` when either condition holds:
  - a handshake occurs with counter == latched burst (burst of `cfg_burst+1` words done);
  - `s_axis_tvalid[g]` is 0 in a cycle where ready would be 1 (source gap).
- Output register: `m_axis_tvalid` clears on m handshake unless reloaded in the same cycle. `m_axis_tdata`, `m_axis_tdest` and `m_cfg_data` change only on reload. The slice setting therefore changes only between wide words, never mid-downsize.
- Config changes to `cfg_slices`/`cfg_burst` during GRANT take effect at the next grant only.
- Counter width is CFG_WIDTH. `cfg_burst` all-ones gives a burst of 2^CFG_WIDTH words; the counter compare is exact, and the counter never wraps past the compare.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tdest`=0, `m_cfg_data`=0, `s_axis_tready`=0, `sts_grant`=0, state=IDLE, `last`=SRC_COUNT-1 (source 0 wins first).
- Reset mid-operation: the word held in the output register is dropped and the grant is cleared immediately (asynchronous).
- Arbitration latency: a request seen in IDLE at cycle n gives ready at cycle n+1.
- Data latency: a source handshake at cycle n puts the word on the m side at cycle n+1.
- Throughput: 1 wide word/cycle within a burst. There is exactly one IDLE cycle between grants.
- Backpressure: `m_axis_tready`=0 with the register full forces ready 0. Neither the burst counter nor the state advances.
- Simultaneous m handshake and source handshake: the register reloads with no bubble.
- A granted source's tvalid drop with a full, stalled register does not end the grant (ready is 0 that cycle).

## Structure
- Shared package `axis_arb_pkg`:
  - state enum (IDLE, GRANT);
  - `SRC_ID_WIDTH = SRC_COUNT > 1 ? $clog2(SRC_COUNT) : 1`.
- Sub-module `axis_rr_picker`: combinational rotate-priority pick, inputs req vector and `last`, outputs valid and index. This sub-module is reused by future mux blocks.
- Top holds the FSM, burst counter, latched config and output register.

## Test plan
- Single source 2 valid continuously, `cfg_burst`=3, `cfg_slices[2]`=3, m always ready:
  - 4 words out with tdest=2 and `m_cfg_data`=3;
  - 1 idle cycle, then the next 4 words.
- Sources 0,1,3 always valid, `cfg_burst`=0: grant order 0,1,3,0,1,3. Each word is tagged with the correct tdest and slice setting.
- `cfg_burst`=7, source 1 drops tvalid after 3 words, source 2 pending: grant moves to source 2 after 3 words, with one idle cycle.
- `m_axis_tready` held 0 for 5 cycles mid-burst:
  - `m_axis_tdata`, `m_axis_tdest` and `m_cfg_data` stable;
  - `s_axis_tready` 0;
  - no words lost or duplicated after release.
- Change `cfg_slices[0]` from 1 to 3 during source 0's burst: all words of that burst carry 1; the next grant of source 0 carries 3.
- Assert `areset` while `m_axis_tvalid`=1 in GRANT:
  - outputs clear immediately;
  - after release, the first grant goes to the lowest valid source index.
